// File: rtl/i3c_pkg.sv
// ---------------------------------------------------------------------------
// i3c_pkg
// Shared types and constants for the I3C recovery datapath.
//   state_e  : recovery transmitter FSM states
//   Crc8Poly : SMBus PEC polynomial (x^8 + x^2 + x + 1)
// ---------------------------------------------------------------------------
package i3c_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDesc,
    StLenL,
    StLenH,
    StData,
    StPec,
    StDone
  } state_e;

  localparam logic [7:0] Crc8Poly = 8'h07;

endpackage

// File: rtl/crc8_smbus.sv
// ---------------------------------------------------------------------------
// crc8_smbus
// Combinational single-byte CRC-8 update (init handled by the caller,
// MSB-first, polynomial Crc8Poly from i3c_pkg).
// Ports:
//   data_i : byte being folded into the CRC
//   crc_i  : CRC value before this byte
//   crc_o  : CRC value after this byte
// ---------------------------------------------------------------------------
module crc8_smbus
  import i3c_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [7:0] crc_i,
  output logic [7:0] crc_o
);

  logic [7:0] crcWork;

  // Byte-wise CRC: XOR the byte into the register, then shift out eight bits.
  always_comb begin
    crcWork = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (crcWork[7]) begin
        crcWork = {crcWork[6:0], 1'b0} ^ Crc8Poly;
      end else begin
        crcWork = {crcWork[6:0], 1'b0};
      end
    end
    crc_o = crcWork;
  end

endmodule

// File: rtl/recovery_transmitter.sv
// ---------------------------------------------------------------------------
// recovery_transmitter
// Sends one recovery read response over the TTI TX path: a descriptor
// carrying the total byte count, a little-endian length field, the payload
// streamed from the CSR reader, and (optionally) an SMBus PEC byte.
// A bus STOP during the byte phases aborts the response.
//
// Build option: define RECOVERY_TX_PEC_EN to append the PEC byte
// (descriptor overhead 3 instead of 2, CRC logic instantiated).
//
// Ports:
//   clk_i, rst_ni                  : clock, async active-low reset
//   start_valid_i/start_ready_o    : response request, res_len_i sampled
//   res_len_i                      : payload byte count
//   res_valid_i/res_ready_o/res_data_i : payload byte stream in
//   tx_desc_valid_o/tx_desc_ready_i/tx_desc_data_o : TTI TX descriptor
//   tx_valid_o/tx_ready_i/tx_data_o: TTI TX data bytes
//   bus_stop_i                     : bus STOP detected, aborts response
//   done_o, abort_o                : completion pulse, abort qualifier
// ---------------------------------------------------------------------------
module recovery_transmitter
  import i3c_pkg::*;
#(
  parameter int unsigned TtiTxDescDataWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_valid_i,
  output logic                          start_ready_o,
  input  logic [15:0]                   res_len_i,
  input  logic                          res_valid_i,
  output logic                          res_ready_o,
  input  logic [7:0]                    res_data_i,
  output logic                          tx_desc_valid_o,
  input  logic                          tx_desc_ready_i,
  output logic [TtiTxDescDataWidth-1:0] tx_desc_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [7:0]                    tx_data_o,
  input  logic                          bus_stop_i,
  output logic                          done_o,
  output logic                          abort_o
);

`ifdef RECOVERY_TX_PEC_EN
  localparam state_e      TailState = StPec;
  localparam logic [16:0] Overhead  = 17'd3;
`else
  localparam state_e      TailState = StDone;
  localparam logic [16:0] Overhead  = 17'd2;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [16:0] descSum;
  logic [15:0] descCount;

  // Total byte count on the wire, clamped so a 0xFFFF payload cannot wrap.
  assign descSum        = {1'b0, len_q} + Overhead;
  assign descCount      = descSum[16] ? 16'hFFFF : descSum[15:0];
  assign tx_desc_data_o = TtiTxDescDataWidth'(descCount);

`ifdef RECOVERY_TX_PEC_EN
  logic [7:0] pec_q, pec_d;
  logic [7:0] crcNext;

  crc8_smbus u_crc8_smbus (
    .data_i (tx_data_o),
    .crc_i  (pec_q),
    .crc_o  (crcNext)
  );

  // PEC covers the length field and payload only; it advances solely on
  // accepted bytes so stalls never fold a byte in twice.
  always_comb begin
    pec_d = pec_q;
    if (state_q == StIdle) begin
      pec_d = 8'h00;
    end else if (tx_valid_o && tx_ready_i &&
                 (state_q inside {StLenL, StLenH, StData})) begin
      pec_d = crcNext;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pec_q <= 8'h00;
    end else begin
      pec_q <= pec_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    abort_d         = abort_q;
    start_ready_o   = 1'b0;
    res_ready_o     = 1'b0;
    tx_desc_valid_o = 1'b0;
    tx_valid_o      = 1'b0;
    tx_data_o       = 8'h00;
    done_o          = 1'b0;
    abort_o         = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_ready_o = 1'b1;
        abort_d       = 1'b0;
        if (start_valid_i) begin
          len_d   = res_len_i;
          cnt_d   = res_len_i;
          state_d = StDesc;
        end
      end
      StDesc: begin
        tx_desc_valid_o = 1'b1;
        if (tx_desc_ready_i) begin
          state_d = StLenL;
        end
      end
      StLenL: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[7:0];
        if (tx_ready_i) begin
          state_d = StLenH;
        end
      end
      StLenH: begin
        tx_valid_o = 1'b1;
        tx_data_o  = len_q[15:8];
        if (tx_ready_i) begin
          state_d = (len_q != 16'd0) ? StData : TailState;
        end
      end
      StData: begin
        // Pass-through: the reader holds its byte stable while we stall.
        tx_valid_o  = res_valid_i;
        res_ready_o = tx_ready_i;
        tx_data_o   = res_data_i;
        if (res_valid_i && tx_ready_i) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = TailState;
          end
        end
      end
`ifdef RECOVERY_TX_PEC_EN
      StPec: begin
        tx_valid_o = 1'b1;
        tx_data_o  = pec_q;
        if (tx_ready_i) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        done_o  = 1'b1;
        abort_o = abort_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A STOP overrides any transition but leaves this cycle's handshake intact.
    if (bus_stop_i && (state_q inside {StLenL, StLenH, StData, StPec})) begin
      state_d = StDone;
      abort_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_recovery_transmitter.sv
// ---------------------------------------------------------------------------
// tb_recovery_transmitter
// Directed-vector bench. The driver pushes the expected descriptor, bytes
// and completion into a scoreboard queue as each response is issued; an
// independent monitor pops and compares whenever the DUT hands something off.
// ---------------------------------------------------------------------------
module tb_recovery_transmitter;

`ifdef RECOVERY_TX_PEC_EN
  localparam bit PecEn = 1'b1;
`else
  localparam bit PecEn = 1'b0;
`endif

  localparam int DescW  = 32;
  localparam int EvDesc = 0;
  localparam int EvByte = 1;
  localparam int EvDone = 2;

  typedef struct {
    int          kind;
    logic [15:0] value;
  } expEv_t;

  logic             clk_i;
  logic             rst_ni;
  logic             start_valid_i;
  logic             start_ready_o;
  logic [15:0]      res_len_i;
  logic             res_valid_i;
  logic             res_ready_o;
  logic [7:0]       res_data_i;
  logic             tx_desc_valid_o;
  logic             tx_desc_ready_i;
  logic [DescW-1:0] tx_desc_data_o;
  logic             tx_valid_o;
  logic             tx_ready_i;
  logic [7:0]       tx_data_o;
  logic             bus_stop_i;
  logic             done_o;
  logic             abort_o;

  expEv_t expQ[$];
  int     vectors     = 0;
  int     miscompares = 0;
  int     cycleCnt    = 0;
  int     lastFire    = -10;
  bit     prevStall   = 1'b0;
  logic [7:0] prevData = 8'h00;

  recovery_transmitter #(
    .TtiTxDescDataWidth (DescW)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_valid_i   (start_valid_i),
    .start_ready_o   (start_ready_o),
    .res_len_i       (res_len_i),
    .res_valid_i     (res_valid_i),
    .res_ready_o     (res_ready_o),
    .res_data_i      (res_data_i),
    .tx_desc_valid_o (tx_desc_valid_o),
    .tx_desc_ready_i (tx_desc_ready_i),
    .tx_desc_data_o  (tx_desc_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .tx_data_o       (tx_data_o),
    .bus_stop_i      (bus_stop_i),
    .done_o          (done_o),
    .abort_o         (abort_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference CRC-8 (poly 0x07) by long division of the 16-bit dividend.
  function automatic logic [7:0] crcByte(input logic [7:0] crc, input logic [7:0] b);
    logic [15:0] r;
    r = {crc ^ b, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
  endfunction

  function automatic logic [7:0] payloadByte(input int idx);
    return 8'(8'h01 + idx * 29);
  endfunction

  function automatic void pushExp(input int kind, input logic [15:0] value);
    expEv_t ev;
    ev.kind  = kind;
    ev.value = value;
    expQ.push_back(ev);
  endfunction

  task automatic expectEq(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops the oldest expectation and compares it against what the DUT just handed off.
  task automatic checkOutput(input int kind, input logic [15:0] act, input string name);
    expEv_t ev;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s unexpected: got %h expected nothing", name, act);
    end else begin
      ev = expQ.pop_front();
      if (ev.kind != kind || ev.value !== act) begin
        miscompares++;
        $display("[TB] FAIL %s: got kind %0d value %h expected kind %0d value %h",
                 name, kind, act, ev.kind, ev.value);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prevStall = 1'b0;
    end else begin
      cycleCnt++;
      if (prevStall && tx_valid_o) begin
        expectEq("tx_data_stable", {8'h00, tx_data_o}, {8'h00, prevData});
      end
      if (tx_desc_valid_o && tx_desc_ready_i) begin
        checkOutput(EvDesc, tx_desc_data_o[15:0], "desc_count");
        expectEq("desc_upper_zero", tx_desc_data_o[31:16], 16'h0000);
      end
      if (tx_valid_o && tx_ready_i) begin
        checkOutput(EvByte, {8'h00, tx_data_o}, "tx_byte");
        lastFire = cycleCnt;
      end
      if (done_o) begin
        checkOutput(EvDone, {15'd0, abort_o}, "done_abort");
        if (!abort_o) expectEq("done_latency", 16'(cycleCnt - lastFire), 16'd1);
      end
      if (abort_o && !done_o) begin
        expectEq("abort_without_done", {15'd0, abort_o}, 16'd0);
      end
      prevStall = tx_valid_o && !tx_ready_i;
      prevData  = tx_data_o;
    end
  end

  // Issues one response. stopMode 1: STOP in an idle cycle after stopAt payload
  // bytes; stopMode 2: STOP coinciding with the handshake of payload byte stopAt.
  task automatic applyStimulus(input logic [15:0] len, input bit toggleReady,
                               input int stopMode, input int stopAt, input bit holdStart);
    int          idx, nPay, budget, stopState;
    bit          accepted, finished, resFire, startFire, abortExp;
    logic [7:0]  crc;
    logic [16:0] sum;

    abortExp = (stopMode != 0);
    if (stopMode == 1)      nPay = stopAt;
    else if (stopMode == 2) nPay = stopAt + 1;
    else                    nPay = int'(len);

    sum = {1'b0, len} + (PecEn ? 17'd3 : 17'd2);
    pushExp(EvDesc, sum[16] ? 16'hFFFF : sum[15:0]);
    crc = 8'h00;
    pushExp(EvByte, {8'h00, len[7:0]});
    crc = crcByte(crc, len[7:0]);
    pushExp(EvByte, {8'h00, len[15:8]});
    crc = crcByte(crc, len[15:8]);
    for (int i = 0; i < nPay; i++) begin
      pushExp(EvByte, {8'h00, payloadByte(i)});
      crc = crcByte(crc, payloadByte(i));
    end
    if (PecEn && !abortExp) pushExp(EvByte, {8'h00, crc});
    pushExp(EvDone, {15'd0, abortExp});

    @(posedge clk_i); #1;
    start_valid_i = 1'b1;
    res_len_i     = len;
    tx_ready_i    = 1'b1;
    bus_stop_i    = 1'b0;
    res_valid_i   = 1'b0;
    idx = 0; accepted = 1'b0; finished = 1'b0; stopState = 0;
    budget = 100 + 4 * nPay;

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk_i);
      resFire   = res_valid_i && res_ready_o;
      startFire = start_valid_i && start_ready_o;
      if (accepted) expectEq("start_ready_busy", {15'd0, start_ready_o}, 16'd0);
      if (done_o) begin
        finished = 1'b1;
        expectEq("res_ready_in_done", {15'd0, res_ready_o}, 16'd0);
        break;
      end
      @(posedge clk_i); #1;
      if (startFire && !accepted) begin
        accepted = 1'b1;
        if (!holdStart) start_valid_i = 1'b0;
      end
      if (resFire) idx++;
      if (toggleReady) tx_ready_i = ~tx_ready_i;
      bus_stop_i = 1'b0;
      if (stopState == 1) begin
        stopState = 2;
      end else if (stopMode != 0 && stopState == 0 && accepted && idx == stopAt) begin
        bus_stop_i = 1'b1;
        stopState  = 1;
      end
      res_valid_i = accepted && (idx < int'(len)) &&
                    (stopState == 0 || (stopMode == 2 && stopState == 1));
      res_data_i  = payloadByte(idx);
    end

    if (!finished) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got no done_o expected done_o within %0d cycles", budget);
      expQ.delete();
    end
    res_valid_i = 1'b0;
    bus_stop_i  = 1'b0;
    tx_ready_i  = 1'b1;
  endtask

  initial begin
    bit seen, sFire;
    rst_ni          = 1'b0;
    start_valid_i   = 1'b0;
    res_len_i       = 16'd0;
    res_valid_i     = 1'b0;
    res_data_i      = 8'h00;
    tx_desc_ready_i = 1'b1;
    tx_ready_i      = 1'b1;
    bus_stop_i      = 1'b0;

    repeat (2) @(negedge clk_i);
    expectEq("rst_start_ready", {15'd0, start_ready_o}, 16'd1);
    expectEq("rst_res_ready", {15'd0, res_ready_o}, 16'd0);
    expectEq("rst_desc_valid", {15'd0, tx_desc_valid_o}, 16'd0);
    expectEq("rst_tx_valid", {15'd0, tx_valid_o}, 16'd0);
    expectEq("rst_done", {15'd0, done_o}, 16'd0);
    expectEq("rst_abort", {15'd0, abort_o}, 16'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    $display("[TB] empty payload");
    applyStimulus(16'd0, 1'b0, 0, 0, 1'b0);
    $display("[TB] single byte payload");
    applyStimulus(16'd1, 1'b0, 0, 0, 1'b0);
    $display("[TB] len 4 with toggling tx_ready_i");
    applyStimulus(16'd4, 1'b1, 0, 0, 1'b0);
    $display("[TB] len 8 with STOP after third payload byte");
    applyStimulus(16'd8, 1'b0, 1, 3, 1'b0);
    $display("[TB] start held high across a response, then back-to-back");
    applyStimulus(16'd5, 1'b0, 0, 0, 1'b1);
    applyStimulus(16'd2, 1'b0, 0, 0, 1'b0);
    $display("[TB] len 0xFFFF saturation with STOP on a handshake");
    applyStimulus(16'hFFFF, 1'b0, 2, 1, 1'b0);

    $display("[TB] reset mid-transfer");
    pushExp(EvDesc, PecEn ? 16'd11 : 16'd10);
    @(posedge clk_i); #1;
    start_valid_i = 1'b1;
    res_len_i     = 16'd8;
    seen          = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk_i);
      sFire = start_valid_i && start_ready_o;
      seen  = tx_desc_valid_o && tx_desc_ready_i;
      @(posedge clk_i); #1;
      if (sFire) start_valid_i = 1'b0;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL reset_desc_timeout: got no descriptor expected one");
      expQ.delete();
    end
    start_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    expectEq("post_rst_start_ready", {15'd0, start_ready_o}, 16'd1);
    expectEq("post_rst_tx_valid", {15'd0, tx_valid_o}, 16'd0);
    repeat (6) @(negedge clk_i);

    expectEq("scoreboard_empty", 16'(expQ.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/recovery_transmitter.md
RECOVERY_TRANSMITTER -- requirements
Module: recovery_transmitter

Interface
REQ-001 SHALL have parameter TtiTxDescDataWidth, default 32, width of the TTI TX descriptor.
REQ-002 SHALL have port clk_i, input, 1, clock.
REQ-003 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have ports start_valid_i (input, 1) and start_ready_o (output, 1), the read-response request handshake.
REQ-005 SHALL have port res_len_i, input, 16, payload byte count, sampled on start handshake.
REQ-006 SHALL have ports res_valid_i (input, 1), res_ready_o (output, 1) and res_data_i (input, 8), the payload byte stream from the CSR reader.
REQ-007 SHALL have ports tx_desc_valid_o (output, 1), tx_desc_ready_i (input, 1) and tx_desc_data_o (output, TtiTxDescDataWidth), the TTI TX descriptor.
REQ-008 SHALL have ports tx_valid_o (output, 1), tx_ready_i (input, 1) and tx_data_o (output, 8), the TTI TX data bytes.
REQ-009 SHALL have port bus_stop_i, input, 1, bus STOP detected (abort).
REQ-010 SHALL have ports done_o (output, 1), a one-cycle completion pulse, and abort_o (output, 1), a one-cycle pulse that qualifies done_o on abort.

Function
REQ-011 SHALL implement the FSM Idle -> Desc -> LenL -> LenH -> Data -> Pec -> Done -> Idle.
REQ-012 Idle: start_ready_o=1; start_valid_i&start_ready_o SHALL latch res_len_i and go to Desc; start requests outside Idle SHALL be back-pressured.
REQ-013 Desc: tx_desc_valid_o=1, tx_desc_data_o[15:0]=res_len+overhead (overhead 3 with PEC, 2 without), computed 17-bit, saturated to 0xFFFF, upper bits 0; desc handshake -> LenL.
REQ-014 LenL/LenH: tx_data_o=len[7:0]/len[15:8], tx_valid_o=1; tx handshake advances; LenH -> Data if len!=0, else Pec (or Done without PEC).
REQ-015 Data: tx_valid_o=res_valid_i, res_ready_o=tx_ready_i, tx_data_o=res_data_i (combinational pass-through); 16-bit down-counter decrements per handshake; leave on the handshake where the counter is 1.
REQ-016 res_ready_o SHALL be 0 in every state except Data.
REQ-017 Pec: tx_data_o=pec, tx_valid_o=1; handshake -> Done.
REQ-018 tx_data_o SHALL be held stable while tx_valid_o&!tx_ready_i, in all sending states.
REQ-019 PEC SHALL be CRC-8, poly 0x07, init 0x00, MSB-first, over LenL, LenH and payload bytes, updated only on tx handshakes; it SHALL be cleared in Idle.
REQ-020 Done: done_o=1 for one cycle -> Idle; the next start SHALL be accepted no earlier than the following cycle.
REQ-021 bus_stop_i in LenL..Pec SHALL move to Done with abort_o=1 the same cycle as done_o; bytes already handshaken are not retracted.
REQ-022 If bus_stop_i coincides with a tx handshake, the handshake SHALL count and the abort still SHALL occur.
REQ-023 bus_stop_i SHALL be ignored in Idle, Desc and Done.

Reset
REQ-024 Reset SHALL force state Idle, the counter, length and PEC to 0, and all valid/ready/pulse outputs to 0 except start_ready_o=1.
REQ-025 Reset mid-transfer SHALL abandon the response without a done_o pulse.

Configuration
REQ-026 With RECOVERY_TX_PEC_EN defined, the Pec state, CRC logic and overhead 3 SHALL be included.
REQ-027 Without RECOVERY_TX_PEC_EN, LenH/Data SHALL go directly to Done, overhead SHALL be 2, and no CRC logic SHALL be built.

Structure
REQ-028 The state_e enum and the CRC-8 polynomial constant SHALL live in i3c_pkg.
REQ-029 A sub-module crc8_smbus (byte in, crc in, crc out, combinational) SHALL be instantiated, only under RECOVERY_TX_PEC_EN.

Verification
REQ-030 PEC on, len=0, ready always high -> desc count 0x0002+1=0x0003; bytes 00,00,00 (PEC 0x00); done_o, abort_o=0.
REQ-031 PEC on, len=1, payload 0x01 -> desc count 0x0004; bytes 01,00,01,6C; done_o one cycle after the last handshake.
REQ-032 len=4, tx_ready_i toggling every cycle -> tx_data_o stable while stalled; exactly 7 handshakes with PEC.
REQ-033 len=8, bus_stop_i after 3rd payload byte -> done_o=abort_o=1 together; res_ready_o=0 afterwards; return to Idle.
REQ-034 start_valid_i held high during a transfer -> start_ready_o=0 until after done_o; second response starts cleanly with PEC re-initialised.
REQ-035 res_len_i=0xFFFF, PEC on -> tx_desc_data_o[15:0]=0xFFFF (saturated).
